// File: rtl/score_sequencer.sv
// Score sequencer: fetches {beat, note} entries from a synchronous ROM and drives
// beat_cnt / tone PWM with an articulation gap between notes. Define SEQ_LOOP_EN to add loop_mode.
module score_sequencer #(
  parameter int ADDR_W     = 6,
  parameter int SCORE_LEN  = 64,
  parameter int NOTE_W     = 5,
  parameter int GAP_CYCLES = 500000,
  parameter int GAP_W      = 20
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
`ifdef SEQ_LOOP_EN
  input  logic              loop_mode,
`endif
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [NOTE_W+3:0] rom_data,
  output logic [3:0]        beat,
  output logic [NOTE_W-1:0] note,
  output logic              beat_en,
  input  logic              beat_finish,
  output logic              tone_en,
  output logic              busy,
  output logic              done,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_PLAY  = 3'd3,
    S_GAP   = 3'd4
  } state_e;

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SCORE_LEN - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          beat_q, beat_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                stop_pend_q, stop_pend_d;
  logic                done_q, done_d;
  logic                busy_q;
  logic                end_hit;
  logic                loop_now;

`ifdef SEQ_LOOP_EN
  assign loop_now = loop_mode && !stop_pend_q;
`else
  assign loop_now = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    beat_d      = beat_q;
    note_d      = note_q;
    gap_d       = gap_q;
    stop_pend_d = stop_pend_q;
    done_d      = 1'b0;
    end_hit     = 1'b0;
    beat_en     = 1'b0;
    tone_en     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d = S_FETCH;
          addr_d  = '0;
        end
      end
      S_FETCH: begin
        if (stop) stop_pend_d = 1'b1;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        beat_d = rom_data[NOTE_W+3:NOTE_W];
        note_d = rom_data[NOTE_W-1:0];
        if (stop || stop_pend_q)                  state_d = S_IDLE;
        else if (rom_data[NOTE_W+3:NOTE_W] == 4'd0) end_hit = 1'b1;
        else                                      state_d = S_PLAY;
      end
      S_PLAY: begin
        // A pending stop mutes at once but keeps beat_cnt running so it ends at 0.
        beat_en = !pause;
        tone_en = !pause && !stop_pend_q && (note_q != '0);
        if (stop) stop_pend_d = 1'b1;
        if (!pause && beat_finish) begin
          if (stop_pend_q)               state_d = S_IDLE;
          else if (addr_q == ADDR_LAST)  end_hit = 1'b1;
          else if (GAP_CYCLES == 0) begin
            state_d = S_FETCH;
            addr_d  = addr_q + ADDR_W'(1);
          end else begin
            state_d = S_GAP;
            gap_d   = '0;
          end
        end
      end
      S_GAP: begin
        if (stop || stop_pend_q) begin
          state_d = S_IDLE;
        end else if (!pause) begin
          if (gap_q == GAP_LAST) begin
            state_d = S_FETCH;
            addr_d  = addr_q + ADDR_W'(1);
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (end_hit) begin
      addr_d = '0;
      if (loop_now) begin
        state_d = S_FETCH;
      end else begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
    end

    if (state_d == S_IDLE) stop_pend_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      beat_q      <= '0;
      note_q      <= '0;
      gap_q       <= '0;
      stop_pend_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      beat_q      <= beat_d;
      note_q      <= note_d;
      gap_q       <= gap_d;
      stop_pend_q <= stop_pend_d;
      done_q      <= done_d;
      busy_q      <= (state_d != S_IDLE);
    end
  end

  assign rom_addr  = addr_q;
  assign beat      = beat_q;
  assign note      = note_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_score_sequencer.sv
// Directed bench for score_sequencer with a ROM model and a beat_cnt model (length 10).
module tb_score_sequencer;
  localparam int ADDR_W = 6, SCORE_LEN = 8, NOTE_W = 5, GAP_CYCLES = 4, GAP_W = 20;
  localparam int BEAT_LEN = 10;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_PLAY = 3'd3, ST_GAP = 3'd4;

  logic clk = 1'b0;
  logic rstn = 1'b0, start = 1'b0, stop = 1'b0, pause = 1'b0;
`ifdef SEQ_LOOP_EN
  logic loop_mode = 1'b0;
`endif
  logic [ADDR_W-1:0] rom_addr;
  logic [NOTE_W+3:0] rom_data;
  logic [3:0]        beat;
  logic [NOTE_W-1:0] note;
  logic              beat_en, beat_finish, tone_en, busy, done;
  logic [2:0]        dbg_state;
  logic [NOTE_W+3:0] rom [0:63];
  logic [3:0]        cnt;
  int tests_run = 0, tests_failed = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) cnt <= 4'd0;
    else if (beat_en) cnt <= (cnt == 4'(BEAT_LEN)) ? 4'd0 : cnt + 4'd1;
  end
  assign beat_finish = (cnt == 4'(BEAT_LEN));

  score_sequencer #(
    .ADDR_W(ADDR_W), .SCORE_LEN(SCORE_LEN), .NOTE_W(NOTE_W),
    .GAP_CYCLES(GAP_CYCLES), .GAP_W(GAP_W)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop), .pause(pause),
`ifdef SEQ_LOOP_EN
    .loop_mode(loop_mode),
`endif
    .rom_addr(rom_addr), .rom_data(rom_data), .beat(beat), .note(note),
    .beat_en(beat_en), .beat_finish(beat_finish), .tone_en(tone_en),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = '0;
  endtask

  task automatic do_reset();
    start = 1'b0; stop = 1'b0; pause = 1'b0;
`ifdef SEQ_LOOP_EN
    loop_mode = 1'b0;
`endif
    rstn = 1'b0; tick(); tick(); rstn = 1'b1; tick();
  endtask

  task automatic pulse_start();
    tick(); start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_play(output int w);
    w = 0;
    while (!beat_en && w < 100) begin tick(); w++; end
  endtask

  task automatic run_beat(output int n, output int tn, output int dn);
    n = 0; tn = 0; dn = 0;
    while (beat_en && n < 100) begin
      n++; if (tone_en) tn++; if (done) dn++;
      tick();
    end
  endtask

  task automatic count_low(output int g);
    g = 0;
    while (!beat_en && busy && g < 100) begin g++; tick(); end
  endtask

  task automatic test_reset();
    rstn = 1'b0; tick();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", done); end
    tests_run++; if (beat_en !== 1'b0) begin tests_failed++; $display("FAIL reset_beat_en: got %b expected 0", beat_en); end
    tests_run++; if (tone_en !== 1'b0) begin tests_failed++; $display("FAIL reset_tone_en: got %b expected 0", tone_en); end
    tests_run++; if (rom_addr !== '0) begin tests_failed++; $display("FAIL reset_rom_addr: got %0d expected 0", rom_addr); end
    tests_run++; if ({beat, note} !== '0) begin tests_failed++; $display("FAIL reset_beat_note: got %0d expected 0", {beat, note}); end
    tests_run++; if (dbg_state !== ST_IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    rstn = 1'b1; tick(); tick();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_idle_after: got busy %b expected 0", busy); end
  endtask

  task automatic test_basic();
    int lat, n, tn, dn, g;
    do_reset(); clear_rom();
    rom[0] = {4'd3, 5'd5}; rom[1] = {4'd3, 5'd0}; rom[2] = {4'd0, 5'd0};
    pulse_start();
    lat = 1;
    while (!beat_en && lat < 20) begin tick(); lat++; end
    tests_run++; if (lat !== 3) begin tests_failed++; $display("FAIL basic_latency: got %0d expected 3", lat); end
    tests_run++; if ({beat, note} !== {4'd3, 5'd5}) begin tests_failed++; $display("FAIL basic_load: got %h expected %h", {beat, note}, {4'd3, 5'd5}); end
    run_beat(n, tn, dn);
    tests_run++; if (n !== 11) begin tests_failed++; $display("FAIL basic_note_len: got %0d expected 11", n); end
    tests_run++; if (tn !== 11) begin tests_failed++; $display("FAIL basic_tone_len: got %0d expected 11", tn); end
    count_low(g);
    tests_run++; if (g !== 6) begin tests_failed++; $display("FAIL basic_gap: got %0d expected 6", g); end
    run_beat(n, tn, dn);
    tests_run++; if (n !== 11) begin tests_failed++; $display("FAIL basic_rest_len: got %0d expected 11", n); end
    tests_run++; if (tn !== 0) begin tests_failed++; $display("FAIL basic_rest_tone: got %0d expected 0", tn); end
    count_low(g);
    tests_run++; if (g !== 6) begin tests_failed++; $display("FAIL basic_end_gap: got %0d expected 6", g); end
    tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL basic_done: got %b expected 1", done); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL basic_busy_fall: got %b expected 0", busy); end
    tests_run++; if (rom_addr !== '0) begin tests_failed++; $display("FAIL basic_addr_end: got %0d expected 0", rom_addr); end
    tick();
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL basic_done_once: got %b expected 0", done); end
  endtask

  task automatic test_full_score();
    int w, n, tn, dn, dtot;
    do_reset(); clear_rom();
    for (int k = 0; k < 8; k++) rom[k] = {4'(k + 7), 5'(k + 1)};
    rom[8] = {4'd2, 5'd3};
    dtot = 0;
    pulse_start();
    for (int k = 0; k < 8; k++) begin
      wait_play(w);
      tests_run++; if (rom_addr !== 6'(k)) begin tests_failed++; $display("FAIL full_addr%0d: got %0d expected %0d", k, rom_addr, k); end
      tests_run++; if ({beat, note} !== {4'(k + 7), 5'(k + 1)}) begin tests_failed++; $display("FAIL full_entry%0d: got %h expected %h", k, {beat, note}, {4'(k + 7), 5'(k + 1)}); end
      run_beat(n, tn, dn);
      dtot += dn;
      tests_run++; if (n !== 11) begin tests_failed++; $display("FAIL full_len%0d: got %0d expected 11", k, n); end
    end
    tests_run++; if (dtot !== 0) begin tests_failed++; $display("FAIL full_early_done: got %0d expected 0", dtot); end
    tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL full_done: got %b expected 1", done); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL full_busy: got %b expected 0", busy); end
    tests_run++; if (rom_addr !== '0) begin tests_failed++; $display("FAIL full_addr_wrap: got %0d expected 0", rom_addr); end
  endtask

  task automatic test_stop();
    int w, n, tn, dn;
    do_reset(); clear_rom();
    for (int k = 0; k < 4; k++) rom[k] = {4'd4, 5'(k + 1)};
    pulse_start();
    for (int k = 0; k < 2; k++) begin wait_play(w); run_beat(n, tn, dn); end
    wait_play(w);
    tests_run++; if (rom_addr !== 6'd2) begin tests_failed++; $display("FAIL stop_addr: got %0d expected 2", rom_addr); end
    tick(); tick(); tick();
    stop = 1'b1;
    tick(); stop = 1'b0; #1;
    tests_run++; if (tone_en !== 1'b0) begin tests_failed++; $display("FAIL stop_mute: got %b expected 0", tone_en); end
    tests_run++; if (beat_en !== 1'b1) begin tests_failed++; $display("FAIL stop_beat_en: got %b expected 1", beat_en); end
    run_beat(n, tn, dn);
    tests_run++; if (n !== 7) begin tests_failed++; $display("FAIL stop_tail: got %0d expected 7", n); end
    tests_run++; if (tn !== 0) begin tests_failed++; $display("FAIL stop_tail_tone: got %0d expected 0", tn); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL stop_idle: got %b expected 0", busy); end
    tests_run++; if ((done | (dn != 0)) !== 1'b0) begin tests_failed++; $display("FAIL stop_no_done: got %b expected 0", done); end
    tests_run++; if (cnt !== 4'd0) begin tests_failed++; $display("FAIL stop_cnt: got %0d expected 0", cnt); end
  endtask

  task automatic test_pause();
    int w, i, be, te, pbad, gcnt, n, tn, dn, g;
    do_reset(); clear_rom();
    rom[0] = {4'd2, 5'd7}; rom[1] = {4'd2, 5'd9};
    pulse_start(); wait_play(w);
    i = 0; be = 0; te = 0; pbad = 0;
    while (dbg_state == ST_PLAY && i < 200) begin
      if (beat_en) be++;
      if (tone_en) te++;
      if (pause && (beat_en || tone_en)) pbad++;
      tick(); i++;
      pause = (i >= 5 && i < 25); #1;
    end
    tests_run++; if (be !== 11) begin tests_failed++; $display("FAIL pause_play_beats: got %0d expected 11", be); end
    tests_run++; if (te !== 11) begin tests_failed++; $display("FAIL pause_play_tone: got %0d expected 11", te); end
    tests_run++; if (pbad !== 0) begin tests_failed++; $display("FAIL pause_play_quiet: got %0d expected 0", pbad); end
    tests_run++; if (i !== 31) begin tests_failed++; $display("FAIL pause_play_cycles: got %0d expected 31", i); end
    tests_run++; if (dbg_state !== ST_GAP) begin tests_failed++; $display("FAIL pause_to_gap: got %0d expected 4", dbg_state); end
    i = 0; gcnt = 0; pbad = 0;
    while (dbg_state == ST_GAP && i < 200) begin
      if (!pause) gcnt++;
      if (beat_en || tone_en) pbad++;
      tick(); i++;
      pause = (i >= 1 && i < 21); #1;
    end
    tests_run++; if (gcnt !== 4) begin tests_failed++; $display("FAIL pause_gap_len: got %0d expected 4", gcnt); end
    tests_run++; if (i !== 24) begin tests_failed++; $display("FAIL pause_gap_cycles: got %0d expected 24", i); end
    tests_run++; if (pbad !== 0) begin tests_failed++; $display("FAIL pause_gap_quiet: got %0d expected 0", pbad); end
    wait_play(w);
    tests_run++; if (note !== 5'd9) begin tests_failed++; $display("FAIL pause_next_note: got %0d expected 9", note); end
    run_beat(n, tn, dn);
    tests_run++; if (n !== 11) begin tests_failed++; $display("FAIL pause_second_len: got %0d expected 11", n); end
    count_low(g);
    tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL pause_done: got %b expected 1", done); end
  endtask

  task automatic test_start_stop();
    do_reset(); clear_rom();
    rom[0] = {4'd3, 5'd5};
    tick(); start = 1'b1; stop = 1'b1;
    tick(); tick(); tick();
    tests_run++; if (dbg_state !== ST_IDLE) begin tests_failed++; $display("FAIL startstop_state: got %0d expected 0", dbg_state); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL startstop_busy: got %b expected 0", busy); end
    tests_run++; if (beat_en !== 1'b0) begin tests_failed++; $display("FAIL startstop_beat_en: got %b expected 0", beat_en); end
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_reset_mid();
    int w;
    do_reset(); clear_rom();
    rom[0] = {4'd3, 5'd5}; rom[1] = {4'd3, 5'd6};
    pulse_start(); wait_play(w);
    tick(); tick(); tick(); tick();
    pulse_start(); // second start while playing must be ignored
    tests_run++; if (rom_addr !== 6'd0) begin tests_failed++; $display("FAIL mid_addr_before: got %0d expected 0", rom_addr); end
    rstn = 1'b0; #1;
    tests_run++; if (beat_en !== 1'b0) begin tests_failed++; $display("FAIL mid_beat_en: got %b expected 0", beat_en); end
    tests_run++; if (tone_en !== 1'b0) begin tests_failed++; $display("FAIL mid_tone_en: got %b expected 0", tone_en); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL mid_busy: got %b expected 0", busy); end
    tests_run++; if ({beat, note} !== '0) begin tests_failed++; $display("FAIL mid_beat_note: got %h expected 0", {beat, note}); end
    tests_run++; if (dbg_state !== ST_IDLE) begin tests_failed++; $display("FAIL mid_state: got %0d expected 0", dbg_state); end
    tick(); rstn = 1'b1;
    pulse_start(); wait_play(w);
    tests_run++; if (w !== 2) begin tests_failed++; $display("FAIL mid_restart_lat: got %0d expected 2", w); end
    tests_run++; if (rom_addr !== 6'd0) begin tests_failed++; $display("FAIL mid_restart_addr: got %0d expected 0", rom_addr); end
    tests_run++; if (note !== 5'd5) begin tests_failed++; $display("FAIL mid_restart_note: got %0d expected 5", note); end
  endtask

`ifdef SEQ_LOOP_EN
  task automatic test_loop();
    int w, n, tn, dn, nb, dl, g;
    do_reset(); clear_rom();
    rom[0] = {4'd3, 5'd5}; rom[1] = {4'd3, 5'd6};
    loop_mode = 1'b1;
    pulse_start();
    for (int k = 0; k < 2; k++) begin wait_play(w); run_beat(n, tn, dn); end
    w = 0; dl = 0; nb = 0;
    while (!beat_en && w < 100) begin
      if (done) dl++;
      if (!busy) nb++;
      tick(); w++;
    end
    tests_run++; if (w !== 8) begin tests_failed++; $display("FAIL loop_wrap_cycles: got %0d expected 8", w); end
    tests_run++; if (dl !== 0) begin tests_failed++; $display("FAIL loop_no_done: got %0d expected 0", dl); end
    tests_run++; if (nb !== 0) begin tests_failed++; $display("FAIL loop_busy: got %0d expected 0", nb); end
    tests_run++; if (rom_addr !== 6'd0) begin tests_failed++; $display("FAIL loop_addr: got %0d expected 0", rom_addr); end
    tests_run++; if (note !== 5'd5) begin tests_failed++; $display("FAIL loop_note: got %0d expected 5", note); end
    loop_mode = 1'b0;
    run_beat(n, tn, dn); wait_play(w); run_beat(n, tn, dn);
    count_low(g);
    tests_run++; if (g !== 6) begin tests_failed++; $display("FAIL loop_final_gap: got %0d expected 6", g); end
    tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL loop_final_done: got %b expected 1", done); end
  endtask
`endif

  initial begin
    clear_rom();
    test_reset();
    test_basic();
    test_full_score();
    test_stop();
    test_pause();
    test_start_stop();
    test_reset_mid();
`ifdef SEQ_LOOP_EN
    test_loop();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/score_sequencer.md
Name: score_sequencer

Overview:
- Controller that plays a score stored in a synchronous ROM by sequencing the beat datapath.
- For each entry it fetches {beat code, note code}, presents the beat code to beat_decoder and the note to the tone generator, and enables beat_cnt until beat_finish.
- Between notes it inserts an articulation gap. Supports start, stop, pause, and an end-of-score marker.
- Sits between the top-level control/buttons and the beat_decoder/beat_cnt/tone PWM blocks.

Parameters:
- ADDR_W, 6, score ROM address width.
- SCORE_LEN, 64, number of ROM entries; must be ≤ 2^ADDR_W.
- NOTE_W, 5, note code width; note code 0 = rest.
- GAP_CYCLES, 500000, muted clk cycles between notes; 0 = no gap.
- GAP_W, 20, gap counter width; must hold GAP_CYCLES.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  level; sampled only in IDLE
- stop  in  1  level; request to abort playback
- pause  in  1  level; freezes playback while high
- rom_addr  out  ADDR_W  score ROM address
- rom_data  in  NOTE_W+4  ROM word, one-cycle read latency; [NOTE_W+3:NOTE_W] = beat code, [NOTE_W-1:0] = note code
- beat  out  4  beat code to beat_decoder
- note  out  NOTE_W  note code to tone generator
- beat_en  out  1  en of beat_cnt
- beat_finish  in  1  from beat_cnt
- tone_en  out  1  unmute tone PWM
- busy  out  1  high in any state but IDLE
- done  out  1  one-cycle pulse on natural end of score

Behaviour:
- Interface: one clock, clk; reset rstn is asynchronous, active-low. All state updates on posedge clk.
- Reset values: state = IDLE; rom_addr = 0; beat = 0; note = 0; beat_en = 0; tone_en = 0; busy = 0; done = 0; gap counter = 0; stop_pend = 0.
- Reset mid-operation returns all of the above immediately. beat_cnt shares rstn, so both restart in lockstep.
- States: IDLE, FETCH, LOAD, PLAY, GAP.
- IDLE
  - start=1 and stop=0 → FETCH with rom_addr = 0.
  - start together with stop is ignored.
- FETCH: one wait cycle for the ROM → LOAD.
- LOAD
  - Latch beat and note from rom_data.
  - Beat code 0 is the end marker → end handling; the entry is not played.
  - Otherwise → PLAY.
  - Beat codes 7–15 are played as given; beat_decoder supplies its default length.
- PLAY
  - beat_en = 1 when pause = 0.
  - tone_en = 1 when pause = 0, stop_pend = 0, and note ≠ 0.
  - On an edge where beat_en = 1 and beat_finish = 1 (beat_cnt clears to 0 on the same edge):
    - if stop_pend → IDLE;
    - else if rom_addr == SCORE_LEN-1 → end handling;
    - else if GAP_CYCLES = 0 → FETCH with rom_addr+1;
    - else → GAP with counter cleared.
- GAP
  - tone_en = 0, beat_en = 0.
  - Counter increments when pause = 0.
  - When the counter reaches GAP_CYCLES-1 with pause = 0 → FETCH with rom_addr+1.
  - stop → IDLE next edge.
- Stop handling
  - stop in FETCH or LOAD sets stop_pend; a pending stop in LOAD → IDLE.
  - stop in PLAY sets stop_pend: tone is muted immediately, and beat_en stays high until beat_finish so beat_cnt is left at 0.
  - stop_pend clears on entering IDLE.
- Pause in FETCH/LOAD does not block the load; it takes effect in PLAY.
- End handling: → IDLE with done = 1 for exactly one cycle; rom_addr → 0.
- busy is registered and equals (state ≠ IDLE). beat and note hold their last loaded value in IDLE.
- Latency
  - start edge → beat_en high: 3 cycles (IDLE→FETCH→LOAD→PLAY).
  - beat_finish edge → next note's beat_en: GAP_CYCLES+2 cycles.
- rom_addr never exceeds SCORE_LEN-1; it does not wrap in place.

Optional Feature:
- Macro: SEQ_LOOP_EN.
- Defined:
  - Adds input port loop_mode (1 bit).
  - At end handling with loop_mode = 1 and stop_pend = 0 → FETCH with rom_addr = 0; no done pulse; busy stays 1.
  - With loop_mode = 0, behaviour is as without the macro.
- Not defined: port absent; end handling always goes to IDLE with done.

Test Plan (bench: GAP_CYCLES=4, SCORE_LEN=8, beat_cnt model with beat_cnt_parameter = 10 for every code):
- ROM {beat=3,note=5},{3,0},{0,x}; pulse start → beat_en rises 3 cycles later. Note 5: tone_en high for 11 cycles. 4-cycle gap. Rest: tone_en low for 11 cycles. Then done pulses once and busy falls the same edge.
- 8 entries, no end marker → all 8 play; done fires after the entry at address 7; rom_addr returns to 0.
- Assert stop 3 cycles into the note at address 2 → tone_en low next cycle; beat_en high until beat_finish; then IDLE with no done; beat_cnt count is 0.
- Hold pause for 20 cycles mid-PLAY, then again mid-GAP → beat_en/tone_en low during each pause; note and gap lengths unchanged overall (11 and 4 active cycles).
- start=1 and stop=1 together in IDLE → stays IDLE. Drop rstn mid-PLAY → all outputs at reset values immediately; a fresh start replays from address 0.
- SEQ_LOOP_EN with loop_mode=1 and a 2-note score → after the end marker, FETCH at address 0, no done, busy stays 1. Clear loop_mode → done after the current pass.
